snake_move_ctrl: RTL and testbench

Consumer of the key-detect output (one-hot `dir` plus `reset` pulse). On each game-tick strobe it advances the snake head one grid cell in the current heading. It checks for wall and self collision, grows the body on food, and holds the segment coordinates in a shift buffer. The VGA renderer reads that buffer through an indexed port, and the food/score logic consumes `eat`.

---
 rtl/snake_pkg.sv | 38 +++
 rtl/snake_move_ctrl_if.sv | 43 ++++
 rtl/snake_seg_buf.sv | 65 ++++++
 rtl/snake_move_ctrl.sv | 149 ++++++++++++++
 tb/tb_snake_move_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared constants, direction helpers and FSM encoding for the snake movement controller.
package snake_pkg;

  localparam int GRID_W_DEF  = 40;
  localparam int GRID_H_DEF  = 30;
  localparam int X_W_DEF     = 6;
  localparam int Y_W_DEF     = 5;
  localparam int MAX_LEN_DEF = 16;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SCAN  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  function automatic logic [3:0] opposite_dir(input logic [3:0] d);
    logic [3:0] r;
    case (d)
      DIR_UP:    r = DIR_DOWN;
      DIR_DOWN:  r = DIR_UP;
      DIR_LEFT:  r = DIR_RIGHT;
      DIR_RIGHT: r = DIR_LEFT;
      default:   r = 4'b0000;
    endcase
    return r;
  endfunction

  function automatic logic is_onehot4(input logic [3:0] d);
    return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/snake_move_ctrl_if.sv
// Bundle of the key-detect inputs, food inputs, renderer read port and status outputs.
interface snake_move_ctrl_if import snake_pkg::*; #(
  parameter int X_W     = X_W_DEF,
  parameter int Y_W     = Y_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  // Strobes (tick, game_reset, eat) are single-cycle pulses; no ready back-pressure:
  // a tick is accepted only while busy and game_over are both low, otherwise dropped.
  logic             tick;
  logic [3:0]       dir;
  logic             game_reset;
  logic [X_W-1:0]   food_x;
  logic [Y_W-1:0]   food_y;
  logic             food_valid;
  logic [IDX_W-1:0] rd_idx;
  logic [X_W-1:0]   rd_x;
  logic [Y_W-1:0]   rd_y;
  logic             rd_valid;
  logic [X_W-1:0]   head_x;
  logic [Y_W-1:0]   head_y;
  logic [LEN_W-1:0] length;
  logic [3:0]       heading;
  logic             eat;
  logic             busy;
  logic             game_over;
  state_t           dbg_state;

  modport master (
    output tick, dir, game_reset, food_x, food_y, food_valid, rd_idx,
    input  rd_x, rd_y, rd_valid, head_x, head_y, length, heading, eat, busy, game_over,
           dbg_state
  );

  modport slave (
    input  tick, dir, game_reset, food_x, food_y, food_valid, rd_idx,
    output rd_x, rd_y, rd_valid, head_x, head_y, length, heading, eat, busy, game_over,
           dbg_state
  );

endinterface

// File: rtl/snake_seg_buf.sv
// Segment coordinate shift register: head at index 0, registered read port, combinational compare tap.
module snake_seg_buf import snake_pkg::*; #(
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int MAX_LEN  = MAX_LEN_DEF,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 10,
  parameter int INIT_Y   = 15,
  parameter int IDX_W    = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_init,
  input  logic             shift_en,
  input  logic [X_W-1:0]   in_x,
  input  logic [Y_W-1:0]   in_y,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [X_W-1:0]   rd_x,
  output logic [Y_W-1:0]   rd_y,
  input  logic [IDX_W-1:0] cmp_idx,
  output logic [X_W-1:0]   cmp_x,
  output logic [Y_W-1:0]   cmp_y,
  output logic [X_W-1:0]   head_x,
  output logic [Y_W-1:0]   head_y
);

  logic [X_W-1:0] seg_x [MAX_LEN];
  logic [Y_W-1:0] seg_y [MAX_LEN];

  // Read samples the array before any shift on the same edge, so a read at SHIFT sees old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? X_W'(INIT_X - i) : '0;
        seg_y[i] <= (i < INIT_LEN) ? Y_W'(INIT_Y) : '0;
      end
      rd_x <= '0;
      rd_y <= '0;
    end else if (load_init) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? X_W'(INIT_X - i) : '0;
        seg_y[i] <= (i < INIT_LEN) ? Y_W'(INIT_Y) : '0;
      end
      rd_x <= '0;
      rd_y <= '0;
    end else begin
      rd_x <= seg_x[rd_idx];
      rd_y <= seg_y[rd_idx];
      if (shift_en) begin
        for (int i = 1; i < MAX_LEN; i++) begin
          seg_x[i] <= seg_x[i-1];
          seg_y[i] <= seg_y[i-1];
        end
        seg_x[0] <= in_x;
        seg_y[0] <= in_y;
      end
    end
  end

  assign cmp_x  = seg_x[cmp_idx];
  assign cmp_y  = seg_y[cmp_idx];
  assign head_x = seg_x[0];
  assign head_y = seg_y[0];

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake movement controller: per-tick head advance, wall/self collision scan, growth on food.
module snake_move_ctrl import snake_pkg::*; #(
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int MAX_LEN  = MAX_LEN_DEF,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 10,
  parameter int INIT_Y   = 15
) (
  input  logic clk,
  input  logic rst,
  snake_move_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_t           state, state_d;
  logic [3:0]       heading_q;
  logic [X_W-1:0]   nxt_x;
  logic [Y_W-1:0]   nxt_y;
  logic             eat_r;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] scan_last;
  logic [LEN_W-1:0] length_q;
  logic             rd_valid_q;

  logic [X_W-1:0]   head_x, cmp_x, cand_x;
  logic [Y_W-1:0]   head_y, cmp_y, cand_y;
  logic [3:0]       new_hd;
  logic             wall, food_hit, hit, start, shift_en;
  logic [LEN_W-1:0] scan_n;

  snake_seg_buf #(
    .X_W(X_W), .Y_W(Y_W), .MAX_LEN(MAX_LEN),
    .INIT_LEN(INIT_LEN), .INIT_X(INIT_X), .INIT_Y(INIT_Y), .IDX_W(IDX_W)
  ) u_seg_buf (
    .clk(clk), .rst(rst),
    .load_init(bus.game_reset), .shift_en(shift_en),
    .in_x(nxt_x), .in_y(nxt_y),
    .rd_idx(bus.rd_idx), .rd_x(bus.rd_x), .rd_y(bus.rd_y),
    .cmp_idx(scan_idx), .cmp_x(cmp_x), .cmp_y(cmp_y),
    .head_x(head_x), .head_y(head_y)
  );

  // Candidate move for a tick arriving now; only meaningful in RUN.
  always_comb begin
    new_hd = heading_q;
    if (is_onehot4(bus.dir) && (bus.dir != opposite_dir(heading_q))) new_hd = bus.dir;
    cand_x = head_x;
    cand_y = head_y;
    case (new_hd)
      DIR_UP:    cand_y = head_y - Y_W'(1);
      DIR_DOWN:  cand_y = head_y + Y_W'(1);
      DIR_LEFT:  cand_x = head_x - X_W'(1);
      default:   cand_x = head_x + X_W'(1);
    endcase
    wall = ((head_x == '0) && (new_hd == DIR_LEFT)) ||
           ((head_x == X_W'(GRID_W - 1)) && (new_hd == DIR_RIGHT)) ||
           ((head_y == '0) && (new_hd == DIR_UP)) ||
           ((head_y == Y_W'(GRID_H - 1)) && (new_hd == DIR_DOWN));
    food_hit = bus.food_valid && (cand_x == bus.food_x) && (cand_y == bus.food_y);
    // Tail is only compared when growing, since otherwise it vacates its cell this move.
    scan_n = length_q - LEN_W'(1) + LEN_W'(food_hit);
    hit    = (nxt_x == cmp_x) && (nxt_y == cmp_y);
  end

  always_comb begin
    state_d  = state;
    start    = 1'b0;
    shift_en = 1'b0;
    case (state)
      ST_RUN: begin
        if (bus.tick) begin
          start = 1'b1;
          if (wall)               state_d = ST_OVER;
          else if (scan_n == '0)  state_d = ST_SHIFT;
          else                    state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (hit)                          state_d = ST_OVER;
        else if (scan_idx == scan_last)   state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        state_d  = ST_RUN;
      end
      default: state_d = ST_OVER;
    endcase
    if (bus.game_reset) begin
      state_d  = ST_RUN;
      start    = 1'b0;
      shift_en = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      heading_q  <= DIR_RIGHT;
      nxt_x      <= '0;
      nxt_y      <= '0;
      eat_r      <= 1'b0;
      scan_idx   <= '0;
      scan_last  <= '0;
      length_q   <= LEN_W'(INIT_LEN);
      rd_valid_q <= 1'b0;
    end else if (bus.game_reset) begin
      heading_q  <= DIR_RIGHT;
      nxt_x      <= '0;
      nxt_y      <= '0;
      eat_r      <= 1'b0;
      scan_idx   <= '0;
      scan_last  <= '0;
      length_q   <= LEN_W'(INIT_LEN);
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= (LEN_W'(bus.rd_idx) < length_q);
      if (start) begin
        heading_q <= new_hd;
        nxt_x     <= cand_x;
        nxt_y     <= cand_y;
        eat_r     <= food_hit;
        scan_idx  <= '0;
        scan_last <= IDX_W'(scan_n - LEN_W'(1));
      end
      if (state == ST_SCAN) scan_idx <= scan_idx + IDX_W'(1);
      if (shift_en && eat_r && (length_q < LEN_W'(MAX_LEN))) length_q <= length_q + LEN_W'(1);
    end
  end

  assign bus.head_x    = head_x;
  assign bus.head_y    = head_y;
  assign bus.length    = length_q;
  assign bus.heading   = heading_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.eat       = (state == ST_SHIFT) && eat_r;
  assign bus.busy      = (state == ST_SCAN) || (state == ST_SHIFT);
  assign bus.game_over = (state == ST_OVER);
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Randomized bench for snake_move_ctrl against a queue-based snake game model.
module tb_snake_move_ctrl;
  import snake_pkg::*;

  localparam int GW = 40;
  localparam int GH = 30;
  localparam int ML = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snake_move_ctrl_if #(.X_W(6), .Y_W(5), .MAX_LEN(ML)) bus ();

  snake_move_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: body as coordinate queues, head at front.
  int mx[$];
  int my[$];
  int m_hd;
  bit m_over;

  function automatic void model_reset();
    mx.delete();
    my.delete();
    for (int i = 0; i < 3; i++) begin
      mx.push_back(10 - i);
      my.push_back(15);
    end
    m_hd   = 1;
    m_over = 1'b0;
  endfunction

  function automatic int opp(input int d);
    case (d)
      8: return 4;
      4: return 8;
      2: return 1;
      1: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int pick_hd(input int d);
    if ((d == 8 || d == 4 || d == 2 || d == 1) && d != opp(m_hd)) return d;
    return m_hd;
  endfunction

  function automatic void step_pos(input int hd, output int nx, output int ny);
    nx = mx[0];
    ny = my[0];
    case (hd)
      8: ny = ny - 1;
      4: ny = ny + 1;
      2: nx = nx - 1;
      default: nx = nx + 1;
    endcase
  endfunction

  function automatic void model_tick(input int d, input int fx, input int fy, input int fv,
                                     output int e_busy, output int e_eat);
    int nx, ny, n;
    bit ate;
    e_busy = 0;
    e_eat  = 0;
    if (m_over) return;
    m_hd = pick_hd(d);
    step_pos(m_hd, nx, ny);
    if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
      m_over = 1'b1;
      return;
    end
    ate = (fv != 0) && nx == fx && ny == fy;
    n   = mx.size() - 1 + int'(ate);
    for (int k = 0; k < n; k++) begin
      if (mx[k] == nx && my[k] == ny) begin
        m_over = 1'b1;
        e_busy = k + 1;
        return;
      end
    end
    mx.push_front(nx);
    my.push_front(ny);
    if (!(ate && mx.size() <= ML)) begin
      void'(mx.pop_back());
      void'(my.pop_back());
    end
    e_eat  = int'(ate);
    e_busy = n + 1;
  endfunction

  task automatic check_rd();
    for (int i = 0; i < ML; i++) begin
      @(negedge clk);
      bus.rd_idx = 4'(i);
      @(negedge clk);
      check("rd_valid", int'(bus.rd_valid), int'(i < mx.size()));
      if (i < mx.size()) begin
        check("rd_x", int'(bus.rd_x), mx[i]);
        check("rd_y", int'(bus.rd_y), my[i]);
      end
    end
  endtask

  task automatic check_state(input bit sweep);
    check("head_x", int'(bus.head_x), mx[0]);
    check("head_y", int'(bus.head_y), my[0]);
    check("length", int'(bus.length), mx.size());
    check("heading", int'(bus.heading), m_hd);
    check("game_over", int'(bus.game_over), int'(m_over));
    check("busy_idle", int'(bus.busy), 0);
    if (sweep) check_rd();
  endtask

  task automatic do_tick(input int d, input int fx, input int fy, input int fv,
                         input bit extra, input bit sweep);
    int e_busy, e_eat, cyc, eats;
    model_tick(d, fx, fy, fv, e_busy, e_eat);
    @(negedge clk);
    bus.dir        = 4'(d);
    bus.food_x     = 6'(fx);
    bus.food_y     = 5'(fy);
    bus.food_valid = (fv != 0);
    bus.tick       = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    cyc  = 0;
    eats = 0;
    while (bus.busy && cyc < 64) begin
      if (bus.eat) eats++;
      if (extra && cyc == 0) begin
        bus.tick = 1'b1;
        bus.dir  = 4'(1 << $urandom_range(0, 3));
      end else begin
        bus.tick = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    bus.tick = 1'b0;
    check("busy_cycles", cyc, e_busy);
    check("eat_pulses", eats, e_eat);
    check_state(sweep);
  endtask

  task automatic do_game_reset(input bit with_tick);
    @(negedge clk);
    bus.game_reset = 1'b1;
    bus.tick       = with_tick;
    bus.dir        = 4'(1 << $urandom_range(0, 3));
    @(negedge clk);
    bus.game_reset = 1'b0;
    bus.tick       = 1'b0;
    model_reset();
    check("gr_rd_x", int'(bus.rd_x), 0);
    check("gr_rd_y", int'(bus.rd_y), 0);
    check("gr_rd_valid", int'(bus.rd_valid), 0);
    check_state(1'b1);
  endtask

  initial begin
    int d, fx, fy, fv, hd, nx, ny;
    rst            = 1'b1;
    bus.tick       = 1'b0;
    bus.dir        = 4'b0001;
    bus.game_reset = 1'b0;
    bus.food_x     = '0;
    bus.food_y     = '0;
    bus.food_valid = 1'b0;
    bus.rd_idx     = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_rd_x", int'(bus.rd_x), 0);
    check("rst_eat", int'(bus.eat), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_state_run", int'(bus.dbg_state == ST_RUN), 1);
    check_state(1'b1);

    // Straight move, reversal, non-one-hot, turn up, then two meals.
    do_tick(1, 0, 0, 0, 1'b0, 1'b1);
    do_tick(2, 0, 0, 0, 1'b0, 1'b1);
    do_tick(6, 0, 0, 0, 1'b0, 1'b1);
    do_tick(8, 13, 13, 1, 1'b0, 1'b1);
    do_tick(8, 13, 13, 1, 1'b0, 1'b1);
    do_tick(8, 13, 12, 1, 1'b0, 1'b1);
    // Curl back into the body.
    do_tick(1, 0, 0, 0, 1'b0, 1'b0);
    do_tick(8, 0, 0, 0, 1'b0, 1'b0);
    do_tick(2, 0, 0, 0, 1'b0, 1'b0);
    do_tick(4, 0, 0, 0, 1'b0, 1'b1);
    do_tick(1, 0, 0, 0, 1'b0, 1'b0);
    do_game_reset(1'b1);

    // Run into the right wall, then poke it while over.
    for (int i = 0; i < 29; i++) do_tick(1, 0, 0, 0, 1'b0, 1'b0);
    do_tick(1, 0, 0, 0, 1'b0, 1'b1);
    do_tick(8, 0, 0, 0, 1'b0, 1'b0);
    do_game_reset(1'b0);

    // Grow to full length and eat once more at the cap.
    for (int i = 0; i < 14; i++) do_tick(1, 11 + i, 15, 1, 1'b0, (i >= 12));
    do_game_reset(1'b0);

    // A tick during busy must be dropped.
    do_tick(1, 0, 0, 0, 1'b1, 1'b1);

    for (int it = 0; it < 400; it++) begin
      if (m_over) begin
        do_game_reset(1'($urandom_range(0, 1)));
      end else begin
        if ($urandom_range(0, 9) < 7) d = 1 << $urandom_range(0, 3);
        else                          d = int'($urandom_range(0, 15));
        if ($urandom_range(0, 9) < 3) begin
          hd = pick_hd(d);
          step_pos(hd, nx, ny);
          fx = nx;
          fy = ny;
          fv = (nx >= 0 && nx < GW && ny >= 0 && ny < GH) ? 1 : 0;
        end else begin
          fx = int'($urandom_range(0, GW - 1));
          fy = int'($urandom_range(0, GH - 1));
          fv = int'($urandom_range(0, 1));
        end
        do_tick(d, fx, fy, fv, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
